// File: rtl/mem_pkg.sv
// Shared size encodings and lane helpers for the rv32i data memory.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Byte-lane write enable for a store of the given size at byte offset off.
  function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << off;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Pick the addressed lane out of a full word and sign/zero extend it.
  function automatic logic [31:0] ext_load(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_B:    res = {{24{~uns & sh[7]}}, sh[7:0]};
      SZ_H:    res = {{16{~uns & sh[15]}}, sh[15:0]};
      SZ_W:    res = word;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_mem_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
interface data_mem_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_array.sv
// DEPTH x 32 synchronous single-port RAM with byte write enables and registered read.
// Contents are never reset.
module data_mem_array #(
  parameter int DEPTH     = 4096,
  parameter int AW        = $clog2(DEPTH),
  parameter     INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Write enabled lanes, and register the addressed word for the next stage.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/data_mem.sv
// Data memory for the rv32i MEM stage: decode, error checks, lane steering,
// load extension and a 1- or 2-cycle response pipeline.
module data_mem
  import mem_pkg::*;
#(
  parameter int DEPTH     = 4096,
  parameter int AW        = $clog2(DEPTH),
  parameter     INIT_FILE = "",
  parameter int PIPE_OUT  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  data_mem_if.slave  bus
);

  logic [1:0]    off_s;
  logic          range_err_s;
  logic          err_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   wdata_rep_s;
  logic          mem_we_s;
  logic [31:0]   ram_rdata_s;

  // Sideband carried alongside the RAM read (S1).
  logic          s1_valid_q;
  logic          s1_we_q;
  logic [1:0]    s1_off_q;
  logic [1:0]    s1_size_q;
  logic          s1_uns_q;
  logic          s1_err_q;
  logic [31:0]   s1_rdata_s;

  assign off_s = bus.req_addr[1:0];

  // S0 decode: error detection, word index and store-data replication.
  always_comb begin
    range_err_s = ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH));
    err_s = (bus.req_size == 2'b11) ||
            ((bus.req_size == SZ_H) && bus.req_addr[0]) ||
            ((bus.req_size == SZ_W) && (off_s != 2'b00)) ||
            range_err_s;
    if (range_err_s) begin
      idx_s = {AW{1'b0}};
    end else begin
      idx_s = bus.req_addr[AW+1:2];
    end
    case (bus.req_size)
      SZ_B:    wdata_rep_s = {4{bus.req_wdata[7:0]}};
      SZ_H:    wdata_rep_s = {2{bus.req_wdata[15:0]}};
      default: wdata_rep_s = bus.req_wdata;
    endcase
  end

  // Stores during reset or with any error never touch the array.
  assign mem_we_s = bus.req_valid & bus.req_we & ~err_s & rst_n;

  data_mem_array #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we_s),
    .be_i    (be_of(bus.req_size, off_s)),
    .addr_i  (idx_s),
    .wdata_i (wdata_rep_s),
    .rdata_o (ram_rdata_s)
  );

  // S1 sideband register; valid clears asynchronously so in-flight responses vanish on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_we_q    <= 1'b0;
      s1_off_q   <= 2'b00;
      s1_size_q  <= 2'b00;
      s1_uns_q   <= 1'b0;
      s1_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= bus.req_valid;
      s1_we_q    <= bus.req_we;
      s1_off_q   <= off_s;
      s1_size_q  <= bus.req_size;
      s1_uns_q   <= bus.req_unsigned;
      s1_err_q   <= err_s;
    end
  end

  // S1 lane select and extension; stores, errors and idle cycles return zero.
  always_comb begin
    if (s1_valid_q && !s1_we_q && !s1_err_q) begin
      s1_rdata_s = ext_load(ram_rdata_s, s1_off_q, s1_size_q, s1_uns_q);
    end else begin
      s1_rdata_s = 32'h0000_0000;
    end
  end

  generate
    if (PIPE_OUT != 0) begin : g_pipe
      logic        s2_valid_q;
      logic [31:0] s2_rdata_q;
      logic        s2_err_q;

      // S2 output register for the 2-cycle latency option.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_valid_q <= 1'b0;
          s2_rdata_q <= 32'h0000_0000;
          s2_err_q   <= 1'b0;
        end else begin
          s2_valid_q <= s1_valid_q;
          s2_rdata_q <= s1_rdata_s;
          s2_err_q   <= s1_valid_q & s1_err_q;
        end
      end

      assign bus.rsp_valid = s2_valid_q;
      assign bus.rsp_rdata = s2_rdata_q;
      assign bus.rsp_err   = s2_err_q;
    end else begin : g_nopipe
      assign bus.rsp_valid = s1_valid_q;
      assign bus.rsp_rdata = s1_rdata_s;
      assign bus.rsp_err   = s1_valid_q & s1_err_q;
    end
  endgenerate

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: drives one PIPE_OUT=0 and one PIPE_OUT=1 instance
// with identical stimulus and checks each against hand-computed expectations.
module tb_data_mem;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  typedef struct packed {
    logic        v0;
    logic [31:0] d0;
    logic        e0;
    logic        v1_early;
    logic        v1;
    logic [31:0] d1;
    logic        e1;
    logic        v0_late;
  } obs_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  data_mem_if bus0 ();
  data_mem_if bus1 ();

  data_mem #(.DEPTH(DEPTH), .AW(AW), .INIT_FILE(""), .PIPE_OUT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  data_mem #(.DEPTH(DEPTH), .AW(AW), .INIT_FILE(""), .PIPE_OUT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input vec_t x);
    bus0.req_valid = v;          bus1.req_valid = v;
    bus0.req_we = x.we;          bus1.req_we = x.we;
    bus0.req_size = x.size;      bus1.req_size = x.size;
    bus0.req_unsigned = x.uns;   bus1.req_unsigned = x.uns;
    bus0.req_addr = x.addr;      bus1.req_addr = x.addr;
    bus0.req_wdata = x.wdata;    bus1.req_wdata = x.wdata;
  endtask

  // One isolated request; samples both DUTs one and two cycles after acceptance.
  task automatic xact(input vec_t x, output obs_t o);
    @(negedge clk);
    drive(1'b1, x);
    @(posedge clk); #1;
    drive(1'b0, '0);
    o.v0 = bus0.rsp_valid; o.d0 = bus0.rsp_rdata; o.e0 = bus0.rsp_err;
    o.v1_early = bus1.rsp_valid;
    @(posedge clk); #1;
    o.v1 = bus1.rsp_valid; o.d1 = bus1.rsp_rdata; o.e1 = bus1.rsp_err;
    o.v0_late = bus0.rsp_valid;
  endtask

  task automatic test_reset();
    drive(1'b0, '0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus0.rsp_valid !== 1'b0 || bus0.rsp_rdata !== 32'h0 || bus0.rsp_err !== 1'b0 ||
        bus1.rsp_valid !== 1'b0 || bus1.rsp_rdata !== 32'h0 || bus1.rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got v0=%b d0=%h e0=%b v1=%b d1=%h e1=%b, want all zero",
               bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_err, bus1.rsp_valid, bus1.rsp_rdata, bus1.rsp_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_table(input string tag, input vec_t tbl [], input int n);
    obs_t o;
    for (int i = 0; i < n; i++) begin
      xact(tbl[i], o);
      n_cmp++;
      if (o.v0 !== 1'b1 || o.d0 !== tbl[i].exp_d || o.e0 !== tbl[i].exp_e || o.v1_early !== 1'b0) begin
        n_bad++;
        $display("FAIL %s[%0d] lat1: got v=%b d=%h e=%b pipe_v=%b, want v=1 d=%h e=%b pipe_v=0",
                 tag, i, o.v0, o.d0, o.e0, o.v1_early, tbl[i].exp_d, tbl[i].exp_e);
      end
      n_cmp++;
      if (o.v1 !== 1'b1 || o.d1 !== tbl[i].exp_d || o.e1 !== tbl[i].exp_e || o.v0_late !== 1'b0) begin
        n_bad++;
        $display("FAIL %s[%0d] lat2: got v=%b d=%h e=%b nopipe_v=%b, want v=1 d=%h e=%b nopipe_v=0",
                 tag, i, o.v1, o.d1, o.e1, o.v0_late, tbl[i].exp_d, tbl[i].exp_e);
      end
    end
  endtask

  task automatic test_store_load();
    vec_t t [];
    t = new[8];
    //           we    size   uns   addr          wdata         exp_d         err
    t[0] = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    t[1] = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    t[2] = '{1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,         32'hFFFF_FFDE, 1'b0};
    t[3] = '{1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,         32'h0000_00DE, 1'b0};
    t[4] = '{1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0,         32'hFFFF_BEEF, 1'b0};
    t[5] = '{1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,         32'h0000_DEAD, 1'b0};
    t[6] = '{1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_00AA, 32'h0000_0000, 1'b0};
    t[7] = '{1'b0, 2'b10, 1'b1, 32'h0000_0010, 32'h0,         32'hDEAD_AAEF, 1'b0};
    run_table("store_load", t, 8);
  endtask

  task automatic test_errors();
    vec_t t [];
    t = new[7];
    t[0] = '{1'b1, 2'b10, 1'b0, 32'h0000_0012, 32'h1111_1111, 32'h0000_0000, 1'b1};
    t[1] = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_AAEF, 1'b0};
    t[2] = '{1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0,         32'h0000_0000, 1'b1};
    t[3] = '{1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1};
    t[4] = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_0000, 1'b1};
    t[5] = '{1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'h2222_2222, 32'h0000_0000, 1'b1};
    t[6] = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_AAEF, 1'b0};
    run_table("errors", t, 7);
  endtask

  task automatic test_back_to_back();
    vec_t t [12];
    t[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h1234_5678, 32'h0000_0000, 1'b0};
    t[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'h1234_5678, 1'b0};
    t[2]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'h0000_009C, 32'h0000_0000, 1'b0};
    t[3]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0021, 32'h0,         32'h0000_009C, 1'b0};
    t[4]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0021, 32'h0,         32'hFFFF_FF9C, 1'b0};
    t[5]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_8001, 32'h0000_0000, 1'b0};
    t[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0,         32'hFFFF_8001, 1'b0};
    t[7]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'h8001_9C78, 1'b0};
    t[8]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0020, 32'h0,         32'h0000_9C78, 1'b0};
    t[9]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0024, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    t[10] = '{1'b0, 2'b00, 1'b0, 32'h0000_0027, 32'h0,         32'hFFFF_FFCA, 1'b0};
    t[11] = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_AAEF, 1'b0};
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i < 12) drive(1'b1, t[i]);
      else        drive(1'b0, '0);
      @(posedge clk); #1;
      n_cmp++;
      if (i < 12) begin
        if (bus0.rsp_valid !== 1'b1 || bus0.rsp_rdata !== t[i].exp_d || bus0.rsp_err !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_lat1[%0d]: got v=%b d=%h e=%b, want v=1 d=%h e=0",
                   i, bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_err, t[i].exp_d);
        end
      end else if (bus0.rsp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_lat1_tail: got v=%b, want v=0", bus0.rsp_valid);
      end
      n_cmp++;
      if (i == 0) begin
        if (bus1.rsp_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_lat2_head: got v=%b, want v=0", bus1.rsp_valid);
        end
      end else if (bus1.rsp_valid !== 1'b1 || bus1.rsp_rdata !== t[i-1].exp_d || bus1.rsp_err !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_lat2[%0d]: got v=%b d=%h e=%b, want v=1 d=%h e=0",
                 i - 1, bus1.rsp_valid, bus1.rsp_rdata, bus1.rsp_err, t[i-1].exp_d);
      end
    end
  endtask

  task automatic test_reset_midflight();
    vec_t a;
    vec_t b;
    vec_t chk [];
    a = '{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 32'h0, 1'b0};
    b = '{1'b0, 2'b10, 1'b0, 32'h0000_0024, 32'h0, 32'h0, 1'b0};
    @(negedge clk); drive(1'b1, a);
    @(negedge clk); drive(1'b1, b);
    @(posedge clk); #1;
    drive(1'b0, '0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus0.rsp_valid !== 1'b0 || bus1.rsp_valid !== 1'b0 || bus1.rsp_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_midflight: got v0=%b v1=%b d1=%h, want v0=0 v1=0 d1=0",
               bus0.rsp_valid, bus1.rsp_valid, bus1.rsp_rdata);
    end
    // A store presented during reset must be dropped.
    @(negedge clk);
    drive(1'b1, '{1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0, 1'b0});
    @(negedge clk);
    drive(1'b0, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus0.rsp_valid !== 1'b0 || bus1.rsp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL stale_rsp[%0d]: got v0=%b v1=%b, want 0 0", i, bus0.rsp_valid, bus1.rsp_valid);
      end
    end
    chk = new[2];
    chk[0] = '{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 32'h8001_9C78, 1'b0};
    chk[1] = '{1'b0, 2'b10, 1'b0, 32'h0000_0024, 32'h0, 32'hCAFE_F00D, 1'b0};
    run_table("retained", chk, 2);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    drive(1'b0, '0);
    test_reset();
    test_store_load();
    test_errors();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
